// File: rtl/jt12_decim_pkg.sv
// jt12_decim shared definitions: CIC order, accumulator sizing, clamp helper.
// The clamp helper is only referenced when JT12_DECIM_SAT_EN is defined.
package jt12_decim_pkg;

    localparam int CIC_N  = 3;
    localparam int DEF_DW = 16;
    localparam int DEF_RW = 4;

    function automatic int acc_w(input int dw, input int rw);
        return dw + CIC_N * rw;
    endfunction

    typedef logic signed [acc_w(DEF_DW, DEF_RW)-1:0] acc_t;

    function automatic logic signed [31:0] sat_clamp(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/jt12_decim_if.sv
// Decimated sample output bundle: valid/ready data plus sticky overrun.
// master = producer (jt12_decim), slave = consumer.
interface jt12_decim_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] out_snd;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overrun;
    logic                 clr_ovr;

    modport master (
        output out_snd,
        output out_valid,
        output overrun,
        input  out_ready,
        input  clr_ovr
    );

    modport slave (
        input  out_snd,
        input  out_valid,
        input  overrun,
        output out_ready,
        output clr_ovr
    );
endinterface

// File: rtl/jt12_decim_comb.sv
// One CIC comb stage: y = x - x(previous tick), registered every clk.
// The delay line only advances when a decimated sample passes through.
import jt12_decim_pkg::*;

module jt12_decim_comb #(
    parameter int AW = $bits(acc_t)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic signed [AW-1:0] x,
    output logic signed [AW-1:0] y,
    output logic                 tick_out
);
    logic signed [AW-1:0] dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            dly      <= '0;
            tick_out <= 1'b0;
        end else begin
            y        <= x - dly;
            tick_out <= tick_in;
            if (tick_in)
                dly <= x;
        end
    end

endmodule

// File: rtl/jt12_decim.sv
// Order-3 CIC decimator by 2**RW with gain shift and valid/ready output.
// Define JT12_DECIM_SAT_EN to clamp the gained result instead of wrapping.
import jt12_decim_pkg::*;

module jt12_decim #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_cen,
    input  logic signed [DW-1:0] in_snd,
    input  logic [1:0]           gain,
    jt12_decim_if.master         snd
);
    localparam int AW = acc_w(DW, RW);
    localparam int SW = DW + 3;

    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] i1, i2, i3;
    logic signed [AW-1:0] smp;
    logic                 smp_v;
    logic [RW-1:0]        phase;
    logic                 tick;

    assign x_ext = {{(AW-DW){in_snd[DW-1]}}, in_snd};
    assign tick  = in_cen && (phase == {RW{1'b1}});

    // Integrators wrap modulo 2**AW; the combs undo the wrap exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1    <= '0;
            i2    <= '0;
            i3    <= '0;
            smp   <= '0;
            smp_v <= 1'b0;
            phase <= '0;
        end else begin
            smp_v <= tick;
            if (in_cen) begin
                i1    <= i1 + x_ext;
                i2    <= i2 + i1;
                i3    <= i3 + i2;
                phase <= phase + RW'(1);
            end
            if (tick)
                smp <= i3 + i2;
        end
    end

    logic signed [AW-1:0] cv [CIC_N+1];
    logic                 tv [CIC_N+1];

    assign cv[0] = smp;
    assign tv[0] = smp_v;

    for (genvar k = 0; k < CIC_N; k++) begin : g_comb
        jt12_decim_comb #(.AW(AW)) u_comb (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_in  (tv[k]),
            .x        (cv[k]),
            .y        (cv[k+1]),
            .tick_out (tv[k+1])
        );
    end

    logic signed [DW-1:0] y;
    logic signed [SW-1:0] y_ext;
    logic signed [SW-1:0] scaled;
    logic signed [DW-1:0] res;
    logic                 unused_lsb;

    // Dropping the low CIC_N*RW bits is the >>> by the filter gain R**3.
    assign y          = cv[CIC_N][AW-1 -: DW];
    assign unused_lsb = ^cv[CIC_N][CIC_N*RW-1:0];
    assign y_ext      = {{(SW-DW){y[DW-1]}}, y};
    assign scaled     = y_ext <<< gain;

`ifdef JT12_DECIM_SAT_EN
    logic signed [31:0] clamped;
    logic               unused_sat;

    assign clamped    = sat_clamp(32'(scaled), DW);
    assign res        = clamped[DW-1:0];
    assign unused_sat = ^clamped[31:DW];
`else
    logic unused_msb;

    assign res        = scaled[DW-1:0];
    assign unused_msb = ^scaled[SW-1:DW];
`endif

    logic new_smp;
    logic ovr_set;

    assign new_smp = tv[CIC_N];
    assign ovr_set = new_smp && snd.out_valid && !snd.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd.out_snd   <= '0;
            snd.out_valid <= 1'b0;
            snd.overrun   <= 1'b0;
        end else begin
            if (new_smp) begin
                snd.out_snd   <= res;
                snd.out_valid <= 1'b1;
            end else if (snd.out_valid && snd.out_ready) begin
                snd.out_valid <= 1'b0;
            end
            if (ovr_set)
                snd.overrun <= 1'b1;
            else if (snd.clr_ovr)
                snd.overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt12_decim.sv
// Scoreboard bench for jt12_decim: directed DC, wrap, gain, backpressure, reset.
// Expected gained value follows JT12_DECIM_SAT_EN.
module tb_jt12_decim;

    localparam int DW = 16;

`ifdef JT12_DECIM_SAT_EN
    localparam logic signed [15:0] G1 = 16'sd32767;
`else
    localparam logic signed [15:0] G1 = -16'sd5536;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_cen = 1'b0;
    logic signed [DW-1:0] in_snd = '0;
    logic [1:0]           gain = 2'd0;

    jt12_decim_if #(.DW(DW)) snd ();

    jt12_decim #(.DW(DW), .RW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_cen (in_cen),
        .in_snd (in_snd),
        .gain   (gain),
        .snd    (snd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 chk;
        logic signed [DW-1:0] val;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests  = 0;
    int   fails  = 0;
    int   pops   = 0;
    int   pushes = 0;
    int   vcnt   = 0;
    int   nin    = 0;
    int   settle = 0;
    int   v0     = 0;
    int   p0     = 0;

    task automatic check(input string name,
                         input logic signed [31:0] act,
                         input logic signed [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (snd.out_valid === 1'b1)
            vcnt++;
        if (rst_n && snd.out_valid === 1'b1 && snd.out_ready === 1'b1) begin
            pops++;
            check("no_x", 32'($isunknown(snd.out_snd)), 0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_output: got %0d expected none", snd.out_snd);
            end else begin
                e = q.pop_front();
                if (e.chk)
                    check("sample", snd.out_snd, e.val);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic signed [DW-1:0] v);
        in_snd = v;
        in_cen = 1'b1;
        @(posedge clk);
        #1;
        in_cen = 1'b0;
    endtask

    // Push one expectation per 16 inputs; first three after a change are transient.
    task automatic feed(input logic signed [DW-1:0] v, input int n,
                        input int sp, input bit push,
                        input logic signed [DW-1:0] xv);
        for (int k = 0; k < n; k++) begin
            pulse(v);
            nin++;
            if (nin == 16) begin
                nin = 0;
                if (push) begin
                    q.push_back('{settle >= 3, xv});
                    pushes++;
                end
                settle++;
            end
            clks(sp - 1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        snd.out_ready = 1'b0;
        snd.clr_ovr   = 1'b0;
        clks(3);
        check("rst_valid", snd.out_valid, 0);
        check("rst_snd", snd.out_snd, 0);
        check("rst_ovr", snd.overrun, 0);
        rst_n = 1'b1;
        v0 = vcnt;
        clks(40);
        check("idle_valid", vcnt - v0, 0);

        snd.out_ready = 1'b1;
        settle = 0;
        v0 = vcnt;
        feed(16'sd1000, 8 * 16, 4, 1, 16'sd1000);
        clks(8);
        check("dc_valid_cycles", vcnt - v0, 8);
        check("dc_pops", pops, 8);

        settle = 0;
        feed(-16'sd32768, 2000, 1, 1, -16'sd32768);
        clks(8);
        check("neg_pops", pops, 133);

        settle = 0;
        feed(16'sd30000, 5 * 16, 1, 1, 16'sd30000);
        clks(8);
        gain = 2'd1;
        feed(16'sd30000, 32, 1, 1, G1);
        clks(8);
        gain = 2'd0;
        feed(16'sd30000, 16, 1, 1, 16'sd30000);
        clks(8);

        snd.out_ready = 1'b0;
        feed(16'sd30000, 16, 1, 0, 16'sd0);
        clks(8);
        check("bp_a_valid", snd.out_valid, 1);
        check("bp_a_ovr", snd.overrun, 0);
        check("bp_a_snd", snd.out_snd, 30000);
        gain = 2'd1;
        feed(16'sd30000, 16, 1, 0, 16'sd0);
        clks(8);
        gain = 2'd0;
        check("bp_b_ovr", snd.overrun, 1);
        check("bp_b_snd", snd.out_snd, G1);
        snd.clr_ovr = 1'b1;
        clks(1);
        snd.clr_ovr = 1'b0;
        check("clr_ovr", snd.overrun, 0);
        check("clr_valid", snd.out_valid, 1);

        feed(16'sd30000, 16, 1, 0, 16'sd0);
        clks(3);
        snd.clr_ovr = 1'b1;
        clks(1);
        snd.clr_ovr = 1'b0;
        check("set_wins", snd.overrun, 1);
        check("bp_c_snd", snd.out_snd, 30000);
        snd.clr_ovr = 1'b1;
        clks(1);
        snd.clr_ovr = 1'b0;
        check("clr_again", snd.overrun, 0);

        q.push_back('{1'b1, 16'sd30000});
        pushes++;
        gain = 2'd1;
        feed(16'sd30000, 16, 1, 1, G1);
        clks(3);
        snd.out_ready = 1'b1;
        clks(1);
        check("accept_no_ovr", snd.overrun, 0);
        check("accept_valid", snd.out_valid, 1);
        clks(4);
        gain = 2'd0;
        check("bp_queue", q.size(), 0);

        feed(16'sd1234, 7, 1, 0, 16'sd0);
        rst_n = 1'b0;
        clks(2);
        check("mid_rst_valid", snd.out_valid, 0);
        check("mid_rst_ovr", snd.overrun, 0);
        rst_n = 1'b1;
        nin = 0;
        settle = 0;
        clks(2);
        v0 = vcnt;
        p0 = pops;
        feed(16'sd500, 15, 2, 1, 16'sd500);
        check("early_valid", vcnt - v0, 0);
        feed(16'sd500, 1, 1, 1, 16'sd500);
        clks(3);
        check("lat_edge4", snd.out_valid, 0);
        clks(1);
        check("lat_edge5", snd.out_valid, 1);
        feed(16'sd500, 5 * 16, 2, 1, 16'sd500);
        clks(10);
        check("rst_pops", pops - p0, 6);

        check("queue_empty", q.size(), 0);
        check("pops_total", pops, pushes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
